word_packer_clkb: RTL and testbench

//  Consumer stage in the clkb domain, directly downstream of the clka->clkb bridge.

---
 rtl/word_packer_clkb.sv | 160 ++++++++++++++++
 tb/tb_word_packer_clkb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_packer_clkb.sv
// Byte-to-word packer for the clkb side of the clka->clkb bridge: requests one word at a time,
// assembles returned bytes little-endian and queues completed words in a small output FIFO.
module word_packer_clkb #(
    parameter int WORD_BYTES = 4,
    parameter int OUT_DEPTH  = 2,
    parameter int TIMEOUT    = 63
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [7:0]              data_in,
    input  logic                    data_valid,
    output logic                    data_req,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    timeout_err,
    output logic                    overflow
);

    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int LANES = (WORD_BYTES > 1) ? WORD_BYTES - 1 : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t                  state_reg, state_next;
    logic [TMR_W-1:0]        timer_reg, timer_next;
    logic                    timeout_err_reg, timeout_err_next;
    logic [IDX_W-1:0]        idx_reg;
    logic [7:0]              lane_reg [LANES];
    logic [8*WORD_BYTES-1:0] mem_reg [OUT_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic                    overflow_reg;

    logic                    word_done, word_pending, can_request;
    logic                    full, pop, push_ok;
    logic [8*WORD_BYTES-1:0] word_assembled;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign word_done    = data_valid && (idx_reg == IDX_W'(WORD_BYTES - 1));
    assign word_pending = (idx_reg != '0);
    assign can_request  = enable && ((32'(cnt_reg) + 32'(word_pending)) < OUT_DEPTH);
    assign full         = (cnt_reg == CNT_W'(OUT_DEPTH));
    assign word_valid   = (cnt_reg != '0);
    assign pop          = word_valid && word_ready;
    // A full buffer still accepts the new word when the head leaves in the same cycle.
    assign push_ok      = word_done && (!full || pop);

    assign data_req    = (state_reg == ST_REQ);
    assign timeout_err = timeout_err_reg;
    assign overflow    = overflow_reg;
    assign word_out    = mem_reg[rd_ptr_reg];

    // The byte arriving now completes the top lane directly, without a register hop.
    assign word_assembled[8*WORD_BYTES-1 -: 8] = data_in;
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
            assign word_assembled[8*gi +: 8] = lane_reg[gi];

            always_ff @(posedge clk) begin
                if (reset) begin
                    lane_reg[gi] <= '0;
                end else if (data_valid && (idx_reg == IDX_W'(gi))) begin
                    lane_reg[gi] <= data_in;
                end
            end
        end

        for (gi = 0; gi < OUT_DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= word_assembled;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        timer_next       = timer_reg;
        timeout_err_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (can_request) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                timer_next = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (word_done) begin
                    timer_next = '0;
                    state_next = ST_IDLE;
                end else if (timer_reg == TMR_W'(TIMEOUT - 1)) begin
                    timer_next       = '0;
                    timeout_err_next = 1'b1;
                    state_next       = ST_IDLE;
                end else begin
                    timer_next = timer_reg + TMR_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            timer_reg       <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg      <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            cnt_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (data_valid) begin
                idx_reg <= word_done ? '0 : idx_reg + IDX_W'(1);
            end
            if (push_ok) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push_ok && !pop) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end else if (pop && !push_ok) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (word_done && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_packer_clkb.sv
// Bench for word_packer_clkb: a cycle table, directed corner sequences and a randomized run
// checked against a queue-based reference model.
module tb_word_packer_clkb;

    localparam int WB    = 4;
    localparam int DEPTH = 2;
    localparam int TO    = 63;

    logic        clk = 1'b0;
    logic        reset, enable, data_valid, data_req, word_valid, word_ready, timeout_err, overflow;
    logic [7:0]  data_in;
    logic [31:0] word_out;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;

    typedef struct {
        logic        en, dv, rdy;
        logic [7:0]  d;
        logic        e_req, e_wv;
        logic [31:0] e_word;
        logic        e_to, e_ovf;
    } vec_t;

    vec_t tv [8];

    always #5 clk = ~clk;

    word_packer_clkb #(.WORD_BYTES(WB), .OUT_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_in(data_in), .data_valid(data_valid),
        .data_req(data_req), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .timeout_err(timeout_err), .overflow(overflow)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = 8'h00; word_ready = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (data_req !== 1'b1 && n < 300) begin
            cyc();
            n++;
        end
        chk(name, 32'(data_req), 32'd1);
    endtask

    task automatic send_bytes(input logic [31:0] w, input int nb, input int first);
        for (int i = first; i < first + nb; i++) begin
            data_valid = 1'b1;
            data_in    = w[8*i +: 8];
            cyc();
        end
        data_valid = 1'b0;
    endtask

    // Reference model state for the randomized run
    logic [7:0]  m_part [$];
    logic [31:0] m_q [$];

    initial begin
        int c, n;
        logic [31:0] w;
        bit m_ovf, m_req, m_to, m_inflight, n_req, n_to, pop, pending;
        int m_req_t, t, p_dv, p_rdy;

        tv[0] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tv[3] = '{1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b1, 32'h44332211, 1'b0, 1'b0};
        tv[6] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};
        tv[7] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_data_req", 32'(data_req), 0);
        chk("rst_word_valid", 32'(word_valid), 0);
        chk("rst_word_out", word_out, 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_overflow", 32'(overflow), 0);

        // Single request, table-driven per cycle
        for (int i = 0; i < 8; i++) begin
            enable = tv[i].en; data_valid = tv[i].dv; word_ready = tv[i].rdy; data_in = tv[i].d;
            cyc();
            chk($sformatf("t1_req[%0d]", i), 32'(data_req), 32'(tv[i].e_req));
            chk($sformatf("t1_wv[%0d]", i), 32'(word_valid), 32'(tv[i].e_wv));
            if (tv[i].e_wv) chk($sformatf("t1_word[%0d]", i), word_out, tv[i].e_word);
            chk($sformatf("t1_to[%0d]", i), 32'(timeout_err), 32'(tv[i].e_to));
            chk($sformatf("t1_ovf[%0d]", i), 32'(overflow), 32'(tv[i].e_ovf));
        end
        data_valid = 1'b0;

        // Full buffer blocks further requests; words drain in order
        do_reset();
        enable = 1'b1; word_ready = 1'b0;
        wait_req("t2_req1"); cyc(); send_bytes(32'hA3A2A1A0, 4, 0);
        wait_req("t2_req2"); cyc(); send_bytes(32'hB3B2B1B0, 4, 0);
        n = 0;
        repeat (20) begin
            if (data_req) n++;
            cyc();
        end
        chk("t2_no_req_while_full", n, 0);
        chk("t2_head_a_valid", 32'(word_valid), 1);
        chk("t2_head_a", word_out, 32'hA3A2A1A0);
        word_ready = 1'b1;
        cyc();
        chk("t2_head_b", word_out, 32'hB3B2B1B0);
        chk("t2_head_b_valid", 32'(word_valid), 1);
        chk("t2_no_req_yet", 32'(data_req), 0);
        cyc();
        chk("t2_drained", 32'(word_valid), 0);
        chk("t2_req_after_drain", 32'(data_req), 1);
        enable = 1'b0;

        // Timeout with partial bytes kept
        do_reset();
        enable = 1'b1; word_ready = 1'b1;
        wait_req("t3_req");
        c = cyc_n;
        cyc();
        send_bytes(32'h44332211, 2, 0);
        while (timeout_err !== 1'b1 && cyc_n < c + 200) cyc();
        chk("t3_timeout_seen", 32'(timeout_err), 1);
        chk("t3_timeout_latency", 32'(cyc_n - c), 32'(TO + 1));
        cyc();
        chk("t3_timeout_one_cycle", 32'(timeout_err), 0);
        chk("t3_rerequest", 32'(data_req), 1);
        cyc();
        send_bytes(32'h44332211, 2, 2);
        chk("t3_word_valid", 32'(word_valid), 1);
        chk("t3_word_kept_partial", word_out, 32'h44332211);
        enable = 1'b0;

        // Unsolicited bytes into a full buffer: drop vs. simultaneous pop
        do_reset();
        send_bytes(32'h01020304, 4, 0);
        send_bytes(32'h05060708, 4, 0);
        chk("t4_no_ovf_yet", 32'(overflow), 0);
        send_bytes(32'h090A0B0C, 4, 0);
        chk("t4_ovf_set", 32'(overflow), 1);
        chk("t4_head", word_out, 32'h01020304);
        word_ready = 1'b1;
        cyc();
        chk("t4_second", word_out, 32'h05060708);
        cyc();
        chk("t4_only_two", 32'(word_valid), 0);
        chk("t4_ovf_sticky", 32'(overflow), 1);

        do_reset();
        send_bytes(32'h01020304, 4, 0);
        send_bytes(32'h05060708, 4, 0);
        send_bytes(32'h090A0B0C, 3, 0);
        word_ready = 1'b1; data_valid = 1'b1; data_in = 8'h09;
        cyc();
        data_valid = 1'b0; word_ready = 1'b0;
        chk("t4b_no_ovf", 32'(overflow), 0);
        chk("t4b_head", word_out, 32'h05060708);
        word_ready = 1'b1;
        cyc();
        chk("t4b_tail", word_out, 32'h090A0B0C);
        chk("t4b_tail_valid", 32'(word_valid), 1);
        cyc();
        chk("t4b_empty", 32'(word_valid), 0);

        // Reset mid-burst discards the partial word
        do_reset();
        enable = 1'b1; word_ready = 1'b1;
        wait_req("t5_req");
        cyc();
        send_bytes(32'h0000BBAA, 2, 0);
        reset = 1'b1; data_valid = 1'b1; data_in = 8'hCC;
        cyc();
        chk("t5_req_zero", 32'(data_req), 0);
        chk("t5_wv_zero", 32'(word_valid), 0);
        chk("t5_word_zero", word_out, 0);
        chk("t5_to_zero", 32'(timeout_err), 0);
        chk("t5_ovf_zero", 32'(overflow), 0);
        reset = 1'b0; data_valid = 1'b0;
        wait_req("t5_req_after");
        cyc();
        send_bytes(32'h44332211, 4, 0);
        chk("t5_clean_valid", 32'(word_valid), 1);
        chk("t5_clean_word", word_out, 32'h44332211);

        // Completion on the last timer cycle beats the timeout
        do_reset();
        enable = 1'b1; word_ready = 1'b1;
        wait_req("t6_req");
        c = cyc_n;
        cyc();
        send_bytes(32'hDDCCBBAA, 3, 0);
        enable = 1'b0;
        while (cyc_n < c + TO) cyc();
        data_valid = 1'b1; data_in = 8'hDD;
        cyc();
        data_valid = 1'b0;
        chk("t6_word_valid", 32'(word_valid), 1);
        chk("t6_word", word_out, 32'hDDCCBBAA);
        chk("t6_no_timeout", 32'(timeout_err), 0);
        cyc();
        chk("t6_no_timeout_later", 32'(timeout_err), 0);

        // Randomized run against the reference model
        do_reset();
        m_part.delete(); m_q.delete();
        m_ovf = 0; m_req = 0; m_to = 0; m_inflight = 0; m_req_t = 0; t = 0;
        for (int k = 0; k < 4000; k++) begin
            case (k / 1000)
                0: begin p_dv = 70; p_rdy = 75; end
                1: begin p_dv = 20; p_rdy = 60; end
                2: begin p_dv = 3;  p_rdy = 80; end
                default: begin p_dv = 50; p_rdy = 10; end
            endcase
            enable     = ($urandom_range(0, 9) < 8);
            data_valid = ($urandom_range(0, 99) < p_dv);
            data_in    = 8'($urandom);
            word_ready = ($urandom_range(0, 99) < p_rdy);

            pop     = (m_q.size() > 0) && word_ready;
            pending = (m_part.size() != 0);
            n_req = 0; n_to = 0;
            if (m_inflight && t > m_req_t) begin
                if (data_valid && m_part.size() == WB - 1) m_inflight = 0;
                else if (t - m_req_t == TO) begin m_inflight = 0; n_to = 1; end
            end else if (!m_inflight && enable && (m_q.size() + int'(pending)) < DEPTH) begin
                n_req = 1; m_inflight = 1; m_req_t = t + 1;
            end
            if (pop) void'(m_q.pop_front());
            if (data_valid) begin
                m_part.push_back(data_in);
                if (m_part.size() == WB) begin
                    w = 0;
                    for (int j = 0; j < WB; j++) w[8*j +: 8] = m_part[j];
                    m_part.delete();
                    if (m_q.size() < DEPTH) m_q.push_back(w);
                    else m_ovf = 1;
                end
            end
            m_req = n_req; m_to = n_to; t++;

            cyc();
            chk("rnd_data_req", 32'(data_req), 32'(m_req));
            chk("rnd_timeout_err", 32'(timeout_err), 32'(m_to));
            chk("rnd_word_valid", 32'(word_valid), 32'(m_q.size() > 0));
            chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
            if (m_q.size() > 0) chk("rnd_word_out", word_out, m_q[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
        $fatal(1);
    end

endmodule
